// File: rtl/regfile_sb.sv
// Register file with write-through bypass and a per-register scoreboard that
// stalls issue on RAW (per read port) and WAW hazards against pending writes.
module regfile_sb #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    input  logic [NRD-1:0]      issue_rs_used,
    output logic                stall,
    output logic [NREG-1:0]     busy,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] mem_reg [NREG];
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     cnt_next;
    logic [NRD-1:0]  port_hazard;
    logic            waw_hazard;
    logic            issue_accept;
    logic            wb_active;

    // Writes to x0 are treated as if they never happened, including for bypass.
    assign wb_active = we && (waddr != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] ra;
            logic          wb_hit;
            assign ra     = raddr[gi*AW +: AW];
            assign wb_hit = wb_active && (waddr == ra);
            assign rdata[gi*XLEN +: XLEN] = (ra == '0) ? '0 :
                                            wb_hit     ? wdata : mem_reg[ra];
            // A writeback landing this cycle resolves the dependency in time.
            assign port_hazard[gi] = issue_rs_used[gi] && (ra != '0) &&
                                     busy_reg[ra] && !wb_hit;
        end
    endgenerate

    assign waw_hazard   = (issue_rd != '0) && busy_reg[issue_rd] &&
                          !(wb_active && (waddr == issue_rd));
    assign stall        = issue_valid && ((|port_hazard) || waw_hazard);
    assign issue_accept = issue_valid && !stall;

    // Clear before set so a same-index issue and writeback leaves the bit set.
    always_comb begin
        busy_next = busy_reg;
        if (wb_active) begin
            busy_next[waddr] = 1'b0;
        end
        if (issue_accept && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wb_active) begin
            mem_reg[waddr] <= wdata;
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_next = cnt_next + {{AW{1'b0}}, busy_reg[i]};
        end
    end

    assign busy     = busy_reg;
    assign busy_cnt = cnt_next;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREG, default 32, register count (power of two, >= 2); AW = log2(NREG).
REQ-003 Parameter NRD, default 2, number of independent read ports (1..4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 we  input  1  writeback enable.
REQ-007 waddr  input  AW  writeback register index.
REQ-008 wdata  input  XLEN  writeback data.
REQ-009 raddr  input  NRD*AW  packed read indices; port k in bits [k*AW +: AW].
REQ-010 rdata  output  NRD*XLEN  packed read data; port k in bits [k*XLEN +: XLEN].
REQ-011 issue_valid  input  1  an instruction requests issue this cycle.
REQ-012 issue_rd  input  AW  destination of issuing instruction.
REQ-013 issue_rs_used  input  NRD  per-port flag: raddr port k is a true source of the issuing instruction.
REQ-014 stall  output  1  issue blocked by hazard this cycle.
REQ-015 busy  output  NREG  pending-write bit per register.
REQ-016 busy_cnt  output  AW+1  number of set busy bits.

Function
REQ-017 Register 0 SHALL always read 0; writes to index 0 ignored; issue with issue_rd=0 never sets busy[0]; busy[0] constantly 0.
REQ-018 Reads SHALL be combinational, zero latency, all ports independent and simultaneous.
REQ-019 Write-through bypass: when we=1 and waddr==raddr port k and waddr!=0, rdata port k SHALL equal wdata in the same cycle.
REQ-020 Write SHALL commit at rising edge when rst=1 and we=1; new value visible on the next cycle without bypass.
REQ-021 Hazard for port k: issue_rs_used[k]=1, raddr k !=0, busy[raddr k]=1, and NOT (we=1 and waddr==raddr k).
REQ-022 WAW hazard: issue_rd!=0, busy[issue_rd]=1, and NOT (we=1 and waddr==issue_rd).
REQ-023 stall SHALL be combinational: issue_valid AND (any port hazard OR WAW hazard); stall=0 whenever issue_valid=0.
REQ-024 Accepted issue = issue_valid AND NOT stall; on accepted issue with issue_rd!=0, busy[issue_rd] SHALL set at the edge.
REQ-025 we=1 with waddr!=0 SHALL clear busy[waddr] at the edge (clearing a non-busy bit is legal, no effect).
REQ-026 Simultaneous accepted issue and writeback to the same index SHALL leave busy set (set wins); register data still updated.
REQ-027 busy_cnt SHALL equal popcount(busy), registered-state derived, same-cycle consistent with busy.
REQ-028 Writeback and issue to different indices in the same cycle SHALL both take effect.

Reset
REQ-029 At a rising edge with rst=0: all registers <= 0, all busy <= 0; we and issue_valid ignored that edge.
REQ-030 After reset edge: rdata all 0, busy=0, busy_cnt=0, stall=0.
REQ-031 Reset asserted mid-operation SHALL discard all pending busy bits regardless of in-flight writebacks.
REQ-032 Before first reset edge, register contents and busy are undefined; bench SHALL reset first.

Verification
REQ-033 Reset, then we=1 waddr=5 wdata=0x0000_00AA, raddr0=5 same cycle -> rdata0=0xAA (bypass); next cycle with we=0 -> rdata0=0xAA.
REQ-034 we=1 waddr=0 wdata=0xFFFF_FFFF -> rdata for raddr=0 stays 0 in that and all later cycles; busy[0]=0.
REQ-035 Issue rd=7 accepted -> busy[7]=1, busy_cnt=1; next cycle issue_valid=1, raddr1=7, issue_rs_used=2'b10, we=0 -> stall=1; same with we=1 waddr=7 -> stall=0, busy[7] cleared unless new issue targets 7.
REQ-036 busy[3]=1, issue rd=3 with no writeback -> stall=1 (WAW), busy unchanged; issue rd=3 with we=1 waddr=3 -> stall=0, busy[3] stays 1 (set wins), busy_cnt unchanged.
REQ-037 Issue rd=1..4 on four cycles -> busy_cnt=4; rst=0 one edge -> busy=0, busy_cnt=0, all rdata 0.
REQ-038 Parameter sweep NRD=1,3 and XLEN=64: repeat REQ-033 and REQ-035 per port; all ports read distinct registers simultaneously with correct values.
